// File: rtl/thresholding_cfg_loader.sv
// Threshold configuration sequencer: streams thresholds into the thresholding cfg port with per-channel
// ascending-order checking. Defining THRESH_CFG_VERIFY_EN adds a readback pass that counts mismatches.
module thresholding_cfg_loader #(
    parameter int N = 4,
    parameter int K = 8,
    parameter int C = 4,
    parameter int PE = 2,
    parameter bit SIGNED = 1'b1,
    localparam int CF = C / PE,
    localparam int AW = $clog2(CF) + $clog2(PE) + N
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_vld,
    output logic          s_rdy,
    input  logic [K-1:0]  s_dat,
    output logic          cfg_en,
    output logic          cfg_we,
    output logic [AW-1:0] cfg_a,
    output logic [K-1:0]  cfg_d,
    input  logic          cfg_rack,
    input  logic [K-1:0]  cfg_q,
    output logic          busy,
    output logic          done,
    output logic          order_err,
    output logic [15:0]   mism_cnt
);

    localparam int CFB = (CF > 1) ? $clog2(CF) : 1;
    localparam int PEB = (PE > 1) ? $clog2(PE) : 1;
    localparam logic [N-1:0]   IDX_LAST = N'(2 ** N - 2);
    localparam logic [CFB-1:0] CF_LAST  = CFB'(CF - 1);
    localparam logic [PEB-1:0] PE_LAST  = PEB'(PE - 1);

    if ((C % PE) != 0) begin : g_bad_cfg
        $error("thresholding_cfg_loader: C must be a multiple of PE");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    state_t         state_r;
    logic [N-1:0]   idx_r, idx_nx_s;
    logic [PEB-1:0] pe_r, pe_nx_s;
    logic [CFB-1:0] cf_r, cf_nx_s;
    logic [K-1:0]   prev_r;
    logic           hs_s, last_s, start_acc_s, pending_s;

    // Address packing tolerates PE or CF equal to 1 (zero-width fields).
    function automatic logic [AW-1:0] make_addr(input logic [CFB-1:0] cf, input logic [PEB-1:0] pe,
                                                input logic [N-1:0] idx);
        logic [31:0] a;
        a = (32'(cf) << ($clog2(PE) + N)) | (32'(pe) << N) | 32'(idx);
        return a[AW-1:0];
    endfunction

    function automatic logic not_ascending(input logic [K-1:0] cur, input logic [K-1:0] prev);
        logic r;
        if (SIGNED) r = ($signed(cur) <= $signed(prev));
        else        r = (cur <= prev);
        return r;
    endfunction

    assign hs_s        = s_vld && s_rdy;
    assign start_acc_s = start && (state_r == ST_IDLE);
    assign last_s      = (idx_r == IDX_LAST) && (pe_r == PE_LAST) && (cf_r == CF_LAST);

    // Next address: idx innermost (skipping 2^N-1), then pe, then cf.
    always_comb begin
        idx_nx_s = idx_r + N'(1);
        pe_nx_s  = pe_r;
        cf_nx_s  = cf_r;
        if (idx_r == IDX_LAST) begin
            idx_nx_s = {N{1'b0}};
            if (pe_r == PE_LAST) begin
                pe_nx_s = {PEB{1'b0}};
                cf_nx_s = (cf_r == CF_LAST) ? {CFB{1'b0}} : cf_r + CFB'(1);
            end else begin
                pe_nx_s = pe_r + PEB'(1);
            end
        end else begin
            idx_nx_s = idx_r + N'(1);
        end
    end

    // Sequencer FSM with registered stream and cfg outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            s_rdy     <= 1'b0;
            cfg_en    <= 1'b0;
            cfg_we    <= 1'b0;
            cfg_a     <= {AW{1'b0}};
            cfg_d     <= {K{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            order_err <= 1'b0;
            idx_r     <= {N{1'b0}};
            pe_r      <= {PEB{1'b0}};
            cf_r      <= {CFB{1'b0}};
            prev_r    <= {K{1'b0}};
        end else begin
            done   <= 1'b0;
            cfg_en <= 1'b0;
            cfg_we <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        state_r   <= ST_LOAD;
                        busy      <= 1'b1;
                        s_rdy     <= 1'b1;
                        order_err <= 1'b0;
                        idx_r     <= {N{1'b0}};
                        pe_r      <= {PEB{1'b0}};
                        cf_r      <= {CFB{1'b0}};
                    end
                end
                ST_LOAD: begin
                    if (hs_s) begin
                        cfg_en <= 1'b1;
                        cfg_we <= 1'b1;
                        cfg_a  <= make_addr(cf_r, pe_r, idx_r);
                        cfg_d  <= s_dat;
                        prev_r <= s_dat;
                        if ((idx_r != {N{1'b0}}) && not_ascending(s_dat, prev_r)) order_err <= 1'b1;
                        idx_r  <= idx_nx_s;
                        pe_r   <= pe_nx_s;
                        cf_r   <= cf_nx_s;
                        if (last_s) begin
`ifdef THRESH_CFG_VERIFY_EN
                            state_r <= ST_VERIFY;
`else
                            state_r <= ST_FIN;
                            s_rdy   <= 1'b0;
`endif
                        end
                    end
                end
`ifdef THRESH_CFG_VERIFY_EN
                ST_VERIFY: begin
                    if (hs_s) begin
                        // cfg_d carries the expected value into the readback shift register.
                        cfg_en <= 1'b1;
                        cfg_a  <= make_addr(cf_r, pe_r, idx_r);
                        cfg_d  <= s_dat;
                        idx_r  <= idx_nx_s;
                        pe_r   <= pe_nx_s;
                        cf_r   <= cf_nx_s;
                        if (last_s) begin
                            state_r <= ST_DRAIN;
                            s_rdy   <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!pending_s) state_r <= ST_FIN;
                end
`endif
                ST_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    s_rdy   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef THRESH_CFG_VERIFY_EN
    localparam logic [N-1:0] PEND_MASK = N'((1 << (N - 1)) - 1);

    logic [N-1:0] sr_vld_r;
    logic [K-1:0] sr_dat_r [N];
    logic         rb_bad_s;

    // Only the entry being acknowledged this cycle may remain when DRAIN exits.
    assign pending_s = (cfg_en && !cfg_we) || ((sr_vld_r & PEND_MASK) != {N{1'b0}});
    assign rb_bad_s  = cfg_rack && (!sr_vld_r[N-1] || (cfg_q != sr_dat_r[N-1]));

    // Expected-value delay line aligned to the readback latency, plus mismatch counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_vld_r <= {N{1'b0}};
            for (int i = 0; i < N; i++) sr_dat_r[i] <= {K{1'b0}};
            mism_cnt <= 16'h0000;
        end else begin
            sr_vld_r[0] <= cfg_en && !cfg_we;
            sr_dat_r[0] <= cfg_d;
            for (int i = 1; i < N; i++) begin
                sr_vld_r[i] <= sr_vld_r[i-1];
                sr_dat_r[i] <= sr_dat_r[i-1];
            end
            if (start_acc_s)                               mism_cnt <= 16'h0000;
            else if (rb_bad_s && (mism_cnt != 16'hFFFF))   mism_cnt <= mism_cnt + 16'h0001;
            else                                           mism_cnt <= mism_cnt;
        end
    end
`else
    logic unused_rb_s;

    assign pending_s   = 1'b0;
    assign mism_cnt    = 16'h0000;
    assign unused_rb_s = ^{cfg_rack, cfg_q, pending_s};
`endif

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Scoreboard bench for thresholding_cfg_loader (N=2, C=4, PE=2) with an attached thresholding table
// model; follows THRESH_CFG_VERIFY_EN to exercise the readback pass.
module tb_thresholding_cfg_loader;

    localparam int N   = 2;
    localparam int K   = 8;
    localparam int C   = 4;
    localparam int PE  = 2;
    localparam int L   = 3;
    localparam int TOT = 12;
    localparam int AW  = 4;
`ifdef THRESH_CFG_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic          clk, rst, start, s_vld, s_rdy;
    logic [K-1:0]  s_dat, cfg_d, cfg_q;
    logic          cfg_en, cfg_we, cfg_rack, busy, done, order_err;
    logic [AW-1:0] cfg_a;
    logic [15:0]   mism_cnt;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [K-1:0]  d;
    } op_t;

    op_t         exp_q[$];
    op_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [K-1:0] p1 [TOT];
    logic [K-1:0] p2 [TOT];
    logic [K-1:0] mem [16];
    logic         line_v [N+1];
    logic [K-1:0] line_d [N+1];

    thresholding_cfg_loader #(.N(N), .K(K), .C(C), .PE(PE), .SIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .s_vld(s_vld), .s_rdy(s_rdy), .s_dat(s_dat),
        .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_d(cfg_d),
        .cfg_rack(cfg_rack), .cfg_q(cfg_q), .busy(busy), .done(done),
        .order_err(order_err), .mism_cnt(mism_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stream position -> {cf, pe, idx} address, derived from channel number.
    function automatic logic [AW-1:0] addr_of(input int i);
        int ch;
        ch = i / L;
        return AW'((ch / PE) * (PE * 4) + (ch % PE) * 4 + (i % L));
    endfunction

    function automatic logic exp_order();
        logic r;
        r = 1'b0;
        for (int ch = 0; ch < C; ch++)
            for (int j = 1; j < L; j++)
                if ($signed(p1[ch*L+j]) <= $signed(p1[ch*L+j-1])) r = 1'b1;
        return r;
    endfunction

    function automatic logic [15:0] exp_mism();
        int n;
        n = 0;
        for (int i = 0; i < TOT; i++) if (p1[i] != p2[i]) n++;
        return VER ? 16'(n) : 16'h0000;
    endfunction

    task automatic gen_ascending();
        int v;
        for (int ch = 0; ch < C; ch++) begin
            v = int'($urandom_range(100)) - 128;
            for (int j = 0; j < L; j++) begin
                p1[ch*L+j] = K'(v);
                v = v + 1 + int'($urandom_range(39));
            end
        end
    endtask

    // Thresholding table model: stores writes, answers reads exactly N cycles later.
    initial begin
        cfg_rack = 1'b0;
        cfg_q    = 8'h00;
        for (int j = 0; j < 16; j++) mem[j] = 8'h00;
        for (int j = 0; j <= N; j++) begin
            line_v[j] = 1'b0;
            line_d[j] = 8'h00;
        end
        forever begin
            @(negedge clk);
            line_v[0] = rst && cfg_en && !cfg_we;
            line_d[0] = mem[cfg_a];
            if (rst && cfg_en && cfg_we) mem[cfg_a] = cfg_d;
            @(posedge clk);
            #1;
            for (int j = N; j >= 1; j--) begin
                line_v[j] = line_v[j-1];
                line_d[j] = line_d[j-1];
            end
            cfg_rack = line_v[N];
            cfg_q    = line_d[N];
        end
    end

    // Monitor: every presented cfg op must match the oldest accepted stream value.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && cfg_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cfg_op: cfg_en=1 at cfg_a=%0h with no pending handshake", cfg_a);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("cfg_a", 32'(cfg_a), 32'(mon_e.a));
                    chk("cfg_we", 32'(cfg_we), 32'(mon_e.we));
                    if (mon_e.we) chk("cfg_d", 32'(cfg_d), 32'(mon_e.d));
                end
            end
        end
    end

    task automatic run_load(input int gap_pct, input bit poke);
        int   i, budget, st, dn, dcyc;
        op_t  e;
        logic exp_oe;
        logic [15:0] exp_mc;
        exp_oe = exp_order();
        exp_mc = exp_mism();
        @(posedge clk); #1;
        start = 1'b1;
        st = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("s_rdy_after_start", 32'(s_rdy), 32'd1);
        for (int pass = 0; pass < (VER ? 2 : 1); pass++) begin
            i = 0;
            budget = 400;
            while (i < TOT && budget > 0) begin
                s_vld = ($urandom_range(99) >= gap_pct);
                s_dat = (pass == 0) ? p1[i] : p2[i];
                start = poke && (i == 4);
                @(negedge clk);
                if (s_vld && s_rdy) begin
                    e.we = (pass == 0);
                    e.a  = addr_of(i);
                    e.d  = s_dat;
                    exp_q.push_back(e);
                    i++;
                end
                @(posedge clk); #1;
                budget--;
            end
            if (i < TOT) begin
                checks++;
                errors++;
                $display("FAIL stream_timeout: accepted %0d of %0d values", i, TOT);
            end
        end
        s_vld = 1'b0;
        start = 1'b0;
        dn = 0;
        dcyc = 0;
        for (int b = 0; b < 100 && dn == 0; b++) begin
            @(negedge clk);
            if (done) begin
                dn = 1;
                dcyc = cyc;
            end
        end
        chk("done_seen", 32'(dn), 32'd1);
        if (gap_pct == 0 && !VER) chk("done_latency", 32'(dcyc - st), 32'(TOT + 2));
        chk("order_err", 32'(order_err), 32'(exp_oe));
        chk("mism_cnt", 32'(mism_cnt), 32'(exp_mc));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int i;
        rst   = 1'b0;
        start = 1'b0;
        s_vld = 1'b0;
        s_dat = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_rdy", 32'(s_rdy), 32'd0);
        chk("rst_cfg_en", 32'(cfg_en), 32'd0);
        chk("rst_cfg_we", 32'(cfg_we), 32'd0);
        chk("rst_cfg_a", 32'(cfg_a), 32'd0);
        chk("rst_cfg_d", 32'(cfg_d), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_order_err", 32'(order_err), 32'd0);
        chk("rst_mism_cnt", 32'(mism_cnt), 32'd0);
        rst = 1'b1;

        // Ascending 1,2,3 per channel, identical second pass.
        for (int k = 0; k < TOT; k++) p1[k] = K'(k % L + 1);
        p2 = p1;
        run_load(0, 1'b0);

        // Channel 1 repeats a value; channel 3 ascends through zero (signed); mid-load start ignored.
        p1[3] = 8'h05; p1[4] = 8'h05; p1[5] = 8'h07;
        p1[9] = 8'hFD; p1[10] = 8'hFF; p1[11] = 8'h01;
        p2 = p1;
        run_load(0, 1'b1);

        // Channel 2's third value altered in the readback pass.
        for (int k = 0; k < TOT; k++) p1[k] = K'(k % L + 1);
        p2 = p1;
        p2[8] = 8'h09;
        run_load(0, 1'b0);

        // Random values with 50% valid gaps; last round unordered.
        for (int r = 0; r < 4; r++) begin
            if (r == 3) begin
                for (int k = 0; k < TOT; k++) p1[k] = K'($urandom);
            end else begin
                gen_ascending();
            end
            p2 = p1;
            for (int m = 0; m < r % 3; m++) p2[$urandom_range(TOT-1)] = K'($urandom);
            run_load(50, 1'b0);
        end

        // Reset in the middle of LOAD, then a clean restart from address 0.
        gen_ascending();
        p2 = p1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        for (int b = 0; b < 50 && i < 5; b++) begin
            s_vld = 1'b1;
            s_dat = p1[i];
            @(negedge clk);
            if (s_vld && s_rdy) begin
                exp_q.push_back('{we: 1'b1, a: addr_of(i), d: p1[i]});
                i++;
            end
            @(posedge clk); #1;
        end
        s_dat = p1[5];
        @(posedge clk); #2;
        chk("pre_reset_cfg_en", 32'(cfg_en), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_reset_cfg_en", 32'(cfg_en), 32'd0);
        chk("mid_reset_cfg_we", 32'(cfg_we), 32'd0);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_s_rdy", 32'(s_rdy), 32'd0);
        s_vld = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        run_load(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
